// File: rtl/censor_feeder.sv
`default_nettype none
// ============================================================================
// Module      : censor_feeder
// Description : Converts a valid/ready byte stream into the censor core's
//               per-clock char/bloom_write/enable drive. Dictionary packets
//               load the Bloom filter; text packets are forwarded and then
//               followed by PAD_LEN spaces so the core's delay FIFO drains.
//               Every packet is guaranteed to end in a space.
// Revision    : 1.0 - initial release
// ============================================================================
module censor_feeder #(
   parameter int PAD_LEN = 44,
   parameter int MAX_LEN = 200
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [7:0]  s_data,
   input  logic        s_dict,
   input  logic        s_last,
   output logic [7:0]  char_out,
   output logic        bloom_write,
   output logic        enable,
   output logic        busy,
   output logic        done,
   output logic [15:0] msg_len,
   output logic        len_err
);

   localparam int                 c_pad_w    = (PAD_LEN > 1) ? $clog2(PAD_LEN) : 1;
   localparam logic [c_pad_w-1:0] c_pad_load = c_pad_w'(PAD_LEN - 1);
   localparam logic [c_pad_w-1:0] c_pad_one  = c_pad_w'(1);
   localparam logic [15:0]        c_max_len  = 16'(MAX_LEN);
   localparam logic [7:0]         c_space    = 8'h20;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DICT  = 3'd1,
      ST_TEXT  = 3'd2,
      ST_SPACE = 3'd3,
      ST_PAD   = 3'd4,
      ST_FIN   = 3'd5
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic               r_mode;          // 1 = dictionary packet in progress
   logic               w_mode_next;
   logic               w_mode_cur;      // mode that applies to this cycle's byte
   logic [c_pad_w-1:0] r_pad_cnt;
   logic [c_pad_w-1:0] w_pad_cnt_next;

   logic [7:0]         r_char;
   logic [7:0]         w_char;
   logic               r_bw;
   logic               w_bw;
   logic               r_en;
   logic               w_en;
   logic               r_done;
   logic               w_done;

   logic [15:0]        r_msg_len;
   logic [15:0]        w_msg_len_next;
   logic [15:0]        w_len_inc;
   logic               r_len_err;
   logic               w_len_err_next;
   logic               w_len_start;     // first byte of a text packet
   logic               w_len_step;      // further text char (byte or injected space)

   // State, mode latch and pad counter registers
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_mode    <= 1'b0;
         r_pad_cnt <= '0;
      end else begin
         r_state   <= w_state_next;
         r_mode    <= w_mode_next;
         r_pad_cnt <= w_pad_cnt_next;
      end
   end

   // Next-state logic plus the values the core will see on the following cycle
   always_comb begin
      w_state_next   = r_state;
      w_mode_next    = r_mode;
      w_mode_cur     = r_mode;
      w_pad_cnt_next = r_pad_cnt;
      w_char         = r_char;
      w_bw           = 1'b0;
      w_en           = 1'b0;
      w_done         = 1'b0;
      w_len_start    = 1'b0;
      w_len_step     = 1'b0;
      s_ready        = 1'b0;

      unique case (r_state)
         ST_IDLE, ST_DICT, ST_TEXT: begin
            s_ready = 1'b1;
            if (r_state == ST_IDLE) begin
               w_mode_cur = s_dict;
            end
            if (s_valid) begin
               w_mode_next = w_mode_cur;
               w_char      = s_data;
               w_bw        = w_mode_cur;
               w_en        = 1'b1;
               if (!w_mode_cur) begin
                  w_len_start = (r_state == ST_IDLE);
                  w_len_step  = (r_state != ST_IDLE);
               end
               if (s_last) begin
                  // A packet already ending in a space needs no injected one
                  if (s_data != c_space) begin
                     w_state_next = ST_SPACE;
                  end else if (w_mode_cur) begin
                     w_state_next = ST_FIN;
                  end else begin
                     w_state_next   = ST_PAD;
                     w_pad_cnt_next = c_pad_load;
                  end
               end else begin
                  w_state_next = w_mode_cur ? ST_DICT : ST_TEXT;
               end
            end
         end
         ST_SPACE: begin
            w_char     = c_space;
            w_bw       = r_mode;
            w_en       = 1'b1;
            w_len_step = !r_mode;
            if (r_mode) begin
               w_state_next = ST_FIN;
            end else begin
               w_state_next   = ST_PAD;
               w_pad_cnt_next = c_pad_load;
            end
         end
         ST_PAD: begin
            w_char = c_space;
            w_en   = 1'b1;
            if (r_pad_cnt == '0) begin
               w_state_next = ST_FIN;
            end else begin
               w_pad_cnt_next = r_pad_cnt - c_pad_one;
            end
         end
         ST_FIN: begin
            w_done       = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Saturating text length and the sticky over-length flag
   always_comb begin
      w_len_inc      = (r_msg_len == 16'hFFFF) ? r_msg_len : r_msg_len + 16'd1;
      w_msg_len_next = r_msg_len;
      w_len_err_next = r_len_err;
      if (w_len_start) begin
         w_msg_len_next = 16'd1;
         w_len_err_next = (16'd1 > c_max_len);
      end else if (w_len_step) begin
         w_msg_len_next = w_len_inc;
         if (w_len_inc > c_max_len) begin
            w_len_err_next = 1'b1;
         end
      end
   end

   // Registered core drive and status outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_char    <= 8'h00;
         r_bw      <= 1'b0;
         r_en      <= 1'b0;
         r_done    <= 1'b0;
         r_msg_len <= 16'd0;
         r_len_err <= 1'b0;
      end else begin
         r_char    <= w_char;
         r_bw      <= w_bw;
         r_en      <= w_en;
         r_done    <= w_done;
         r_msg_len <= w_msg_len_next;
         r_len_err <= w_len_err_next;
      end
   end

   assign char_out    = r_char;
   assign bloom_write = r_bw;
   assign enable      = r_en;
   assign done        = r_done;
   assign msg_len     = r_msg_len;
   assign len_err     = r_len_err;
   assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_censor_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_censor_feeder
// Description : Directed self-checking bench for censor_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_censor_feeder;

   logic        clock   = 1'b0;
   logic        reset   = 1'b1;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data  = 8'h00;
   logic        s_dict  = 1'b0;
   logic        s_last  = 1'b0;
   logic        s_ready;
   logic [7:0]  char_out;
   logic        bloom_write;
   logic        enable;
   logic        busy;
   logic        done;
   logic [15:0] msg_len;
   logic        len_err;

   int total = 0;
   int bad   = 0;

   logic [8:0] obs_q[$];     // {bloom_write, char_out} of every enabled cycle
   logic       en_trace[$];  // enable, one entry per cycle
   int         done_cnt = 0;

   always #5 clock = ~clock;

   censor_feeder #(.PAD_LEN(44), .MAX_LEN(200)) dut (
      .clock       (clock),
      .reset       (reset),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_dict      (s_dict),
      .s_last      (s_last),
      .char_out    (char_out),
      .bloom_write (bloom_write),
      .enable      (enable),
      .busy        (busy),
      .done        (done),
      .msg_len     (msg_len),
      .len_err     (len_err)
   );

   // Record what the core would see, sampled mid-cycle
   always @(negedge clock) begin
      if (!reset) begin
         if (enable) obs_q.push_back({bloom_write, char_out});
         en_trace.push_back(enable);
         if (done) done_cnt++;
      end
   end

   task automatic clear_mon();
      obs_q.delete();
      en_trace.delete();
      done_cnt = 0;
   endtask

   // Offer one byte and hold it until the feeder accepts it
   task automatic send_byte(input logic [7:0] d, input logic dict, input logic last,
                            output int waits);
      logic got;
      got    = 1'b0;
      waits  = 0;
      s_data = d; s_dict = dict; s_last = last; s_valid = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         if (s_ready) begin
            got = 1'b1;
            break;
         end
         waits++;
      end
      @(posedge clock); #1;
      s_valid = 1'b0; s_last = 1'b0;
      if (!got) begin
         total++; bad++;
         $display("FAIL send_timeout byte=%h s_ready never rose", d);
      end
   endtask

   // Wait for the done pulse; the final char must be on the bus the cycle before
   task automatic wait_done(input string name, input int bound);
      logic got;
      logic prev_en;
      got     = 1'b0;
      prev_en = 1'b0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clock);
         if (done) begin
            got = 1'b1;
            break;
         end
         prev_en = enable;
      end
      total++;
      if (got !== 1'b1) begin
         bad++;
         $display("FAIL %s_done_timeout seen=%b required=1", name, got);
      end
      total++;
      if (prev_en !== 1'b1) begin
         bad++;
         $display("FAIL %s_done_timing enable_before_done=%b required=1", name, prev_en);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      total++;
      if ({char_out, bloom_write, enable, done, busy, s_ready, len_err} !== {8'h00, 6'b000010}) begin
         bad++;
         $display("FAIL reset_outputs got=%h req=%h",
                  {char_out, bloom_write, enable, done, busy, s_ready, len_err}, {8'h00, 6'b000010});
      end
      total++;
      if (msg_len !== 16'd0) begin
         bad++;
         $display("FAIL reset_msg_len got=%0d req=0", msg_len);
      end
   endtask

   task automatic test_dict_cat();
      logic [8:0] exp_v[4];
      int w;
      exp_v = '{9'h163, 9'h161, 9'h174, 9'h120};
      clear_mon();
      send_byte(8'h63, 1'b1, 1'b0, w);
      send_byte(8'h61, 1'b1, 1'b0, w);
      send_byte(8'h74, 1'b1, 1'b1, w);
      wait_done("dict_cat", 20);
      total++;
      if (obs_q.size() !== 4) begin
         bad++;
         $display("FAIL dict_cat_count got=%0d req=4", obs_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_q[i] !== exp_v[i]) begin
               bad++;
               $display("FAIL dict_cat_char%0d got=%h req=%h", i, obs_q[i], exp_v[i]);
            end
         end
      end
      total++;
      if (done_cnt !== 1) begin
         bad++;
         $display("FAIL dict_cat_done_count got=%0d req=1", done_cnt);
      end
   endtask

   task automatic test_text_space();
      int w;
      int errs;
      logic [8:0] e;
      clear_mon();
      send_byte(8'h68, 1'b0, 1'b0, w);
      send_byte(8'h69, 1'b0, 1'b0, w);
      send_byte(8'h20, 1'b0, 1'b1, w);
      wait_done("text_space", 100);
      total++;
      if (obs_q.size() !== 47) begin
         bad++;
         $display("FAIL text_space_count got=%0d req=47", obs_q.size());
      end else begin
         errs = 0;
         for (int i = 0; i < 47; i++) begin
            e = (i == 0) ? 9'h068 : (i == 1) ? 9'h069 : 9'h020;
            if (obs_q[i] !== e) errs++;
         end
         total++;
         if (errs !== 0) begin
            bad++;
            $display("FAIL text_space_seq wrong_chars=%0d req=0", errs);
         end
      end
      total++;
      if ({msg_len, len_err} !== {16'd3, 1'b0}) begin
         bad++;
         $display("FAIL text_space_len got=%0d/%b req=3/0", msg_len, len_err);
      end
   endtask

   task automatic test_gapped();
      int w;
      int viol;
      int errs;
      logic [8:0] e;
      clear_mon();
      send_byte(8'h61, 1'b0, 1'b0, w);
      @(posedge clock); #1;
      send_byte(8'h62, 1'b0, 1'b1, w);
      viol = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         if (!busy) break;
         if (s_ready) viol++;
      end
      @(posedge clock); #1;
      total++;
      if (viol !== 0) begin
         bad++;
         $display("FAIL gapped_ready_in_tail got=%0d req=0", viol);
      end
      total++;
      if (en_trace.size() < 4) begin
         bad++;
         $display("FAIL gapped_trace_short got=%0d req>=4", en_trace.size());
      end else if ({en_trace[0], en_trace[1], en_trace[2], en_trace[3]} !== 4'b0101) begin
         bad++;
         $display("FAIL gapped_enable got=%b%b%b%b req=0101",
                  en_trace[0], en_trace[1], en_trace[2], en_trace[3]);
      end
      total++;
      if (obs_q.size() !== 47) begin
         bad++;
         $display("FAIL gapped_count got=%0d req=47", obs_q.size());
      end else begin
         errs = 0;
         for (int i = 0; i < 47; i++) begin
            e = (i == 0) ? 9'h061 : (i == 1) ? 9'h062 : 9'h020;
            if (obs_q[i] !== e) errs++;
         end
         total++;
         if (errs !== 0) begin
            bad++;
            $display("FAIL gapped_seq wrong_chars=%0d req=0", errs);
         end
      end
      total++;
      if (done_cnt !== 1) begin
         bad++;
         $display("FAIL gapped_done_count got=%0d req=1", done_cnt);
      end
   endtask

   task automatic test_single_space();
      int w;
      int errs;
      clear_mon();
      send_byte(8'h20, 1'b0, 1'b1, w);
      wait_done("single_space", 100);
      total++;
      if (obs_q.size() !== 45) begin
         bad++;
         $display("FAIL single_space_count got=%0d req=45", obs_q.size());
      end else begin
         errs = 0;
         for (int i = 0; i < 45; i++) if (obs_q[i] !== 9'h020) errs++;
         total++;
         if (errs !== 0) begin
            bad++;
            $display("FAIL single_space_seq wrong_chars=%0d req=0", errs);
         end
      end
      total++;
      if (msg_len !== 16'd1) begin
         bad++;
         $display("FAIL single_space_len got=%0d req=1", msg_len);
      end
   endtask

   task automatic test_len_err();
      int w;
      clear_mon();
      for (int i = 1; i <= 201; i++) begin
         send_byte(8'h78, 1'b0, (i == 201), w);
         if (i == 200) begin
            total++;
            if ({msg_len, len_err} !== {16'd200, 1'b0}) begin
               bad++;
               $display("FAIL len_err_at200 got=%0d/%b req=200/0", msg_len, len_err);
            end
         end
         if (i == 201) begin
            total++;
            if ({msg_len, len_err} !== {16'd201, 1'b1}) begin
               bad++;
               $display("FAIL len_err_at201 got=%0d/%b req=201/1", msg_len, len_err);
            end
         end
      end
      wait_done("len_err", 100);
      total++;
      if (obs_q.size() !== 246) begin
         bad++;
         $display("FAIL len_err_count got=%0d req=246", obs_q.size());
      end
      total++;
      if ({msg_len, len_err} !== {16'd202, 1'b1}) begin
         bad++;
         $display("FAIL len_err_final got=%0d/%b req=202/1", msg_len, len_err);
      end
      clear_mon();
      send_byte(8'h7A, 1'b0, 1'b1, w);
      total++;
      if ({msg_len, len_err} !== {16'd1, 1'b0}) begin
         bad++;
         $display("FAIL len_err_clear got=%0d/%b req=1/0", msg_len, len_err);
      end
      wait_done("len_err_next", 100);
   endtask

   task automatic test_dict_drop();
      logic [8:0] exp_v[4];
      int w;
      exp_v = '{9'h164, 9'h16F, 9'h167, 9'h120};
      clear_mon();
      send_byte(8'h64, 1'b1, 1'b0, w);
      send_byte(8'h6F, 1'b0, 1'b0, w);
      send_byte(8'h67, 1'b0, 1'b1, w);
      wait_done("dict_drop", 20);
      total++;
      if (obs_q.size() !== 4) begin
         bad++;
         $display("FAIL dict_drop_count got=%0d req=4", obs_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_q[i] !== exp_v[i]) begin
               bad++;
               $display("FAIL dict_drop_char%0d got=%h req=%h", i, obs_q[i], exp_v[i]);
            end
         end
      end
      total++;
      if (msg_len !== 16'd2) begin
         bad++;
         $display("FAIL dict_drop_len_held got=%0d req=2", msg_len);
      end
   endtask

   task automatic test_back_to_back();
      int w0;
      int w1;
      clear_mon();
      send_byte(8'h61, 1'b1, 1'b1, w0);
      send_byte(8'h62, 1'b0, 1'b1, w1);
      wait_done("b2b", 100);
      total++;
      if ({w0, w1} !== {32'd0, 32'd2}) begin
         bad++;
         $display("FAIL b2b_accept_waits got=%0d,%0d req=0,2", w0, w1);
      end
      total++;
      if (obs_q.size() !== 48) begin
         bad++;
         $display("FAIL b2b_count got=%0d req=48", obs_q.size());
      end else if ({obs_q[0], obs_q[1], obs_q[2], obs_q[3]} !== {9'h161, 9'h120, 9'h062, 9'h020}) begin
         bad++;
         $display("FAIL b2b_seq got=%h %h %h %h req=161 120 062 020",
                  obs_q[0], obs_q[1], obs_q[2], obs_q[3]);
      end
      total++;
      if (done_cnt !== 2) begin
         bad++;
         $display("FAIL b2b_done_count got=%0d req=2", done_cnt);
      end
   endtask

   task automatic test_reset_pad();
      int w;
      clear_mon();
      send_byte(8'h71, 1'b0, 1'b1, w);
      repeat (34) @(posedge clock);
      #1;
      total++;
      if ({busy, msg_len} !== {1'b1, 16'd2}) begin
         bad++;
         $display("FAIL rst_pad_before got=%b/%0d req=1/2", busy, msg_len);
      end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      total++;
      if ({enable, busy, done, msg_len} !== {3'b000, 16'd0}) begin
         bad++;
         $display("FAIL rst_pad_after got=%b%b%b/%0d req=000/0", enable, busy, done, msg_len);
      end
      clear_mon();
      repeat (4) @(posedge clock);
      #1;
      total++;
      if ({done_cnt, obs_q.size()} !== {32'd0, 32'd0}) begin
         bad++;
         $display("FAIL rst_pad_quiet done=%0d chars=%0d req=0/0", done_cnt, obs_q.size());
      end
      send_byte(8'h72, 1'b0, 1'b1, w);
      total++;
      if ({w, msg_len} !== {32'd0, 16'd1}) begin
         bad++;
         $display("FAIL rst_pad_new_pkt waits=%0d len=%0d req=0/1", w, msg_len);
      end
      wait_done("rst_pad_new", 100);
   endtask

   initial begin
      test_reset();
      test_dict_cat();
      test_text_space();
      test_gapped();
      test_single_space();
      test_len_err();
      test_dict_drop();
      test_back_to_back();
      test_reset_pad();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
